axis_trig_packetizer: RTL and testbench
=======================================

# axis_trig_packetizer

Trigger-armed AXI4-Stream packetizer that inserts TLAST every programmable number of beats and emits a programmable number of packets per trigger. It sits between a free-running acquisition stream (ADC/DSP) and a DMA/FIFO. Unlike the single-shot gate, it discards input while not capturing, so upstream never stalls. It supports runtime length and packet count, auto re-arm, graceful abort and status reporting.

## Interface
- TDATA_WIDTH, 8, data width in bits
- LEN_WIDTH, 20, width of packet-length config; max packet 2^LEN_WIDTH beats
- NPKT_WIDTH, 8, width of packets-per-trigger config and packet counter

Ports:
- aclk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- cfg_len_m1  in  LEN_WIDTH  packet length minus one, in beats
- cfg_npkt  in  NPKT_WIDTH  packets per trigger; 0 = unlimited
- cfg_rearm  in  1  1 = return to ARMED after burst instead of IDLE
- arm  in  1  level; sampled in IDLE
- trig  in  1  trigger; rising edge significant
- abort  in  1  level; requests stop
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  TDATA_WIDTH  input data
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last beat of packet
- m_axis_tdata  out  TDATA_WIDTH  output data (= s_axis_tdata)
- sts_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE
- sts_pkt_cnt  out  NPKT_WIDTH  packets completed in current burst
- done  out  1  one-cycle pulse at burst end

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: arm=1 and abort=0 -> ARMED. Latch cfg_len_m1, cfg_npkt, cfg_rearm into shadow registers. Clear beat and packet counters.
- ARMED: trig rising edge (trig & ~trig_d) -> CAPTURE. abort=1 -> IDLE, with priority over trig.
- CAPTURE: beat counter increments on each accepted beat (s_axis_tvalid & s_axis_tready).
- m_axis_tlast = CAPTURE && beat_cnt == len_m1.
- On an accepted tlast beat: beat_cnt <= 0 and pkt_cnt <= pkt_cnt+1.
- Burst ends on an accepted tlast beat when either condition holds:
  - npkt != 0 and pkt_cnt+1 == npkt, or
  - stop_pending = 1.
- At burst end: done pulses. Next state is ARMED if shadow rearm=1 and stop_pending=0, else IDLE.
- Re-arm reloads shadow config from the cfg_* ports and clears both counters.
- abort in CAPTURE sets stop_pending. The current packet completes normally, so no truncated packet is ever emitted. stop_pending clears on leaving CAPTURE.
- Unlimited mode (npkt=0): pkt_cnt wraps modulo 2^NPKT_WIDTH, and the burst ends only via abort.
- cfg_* changes outside IDLE or a re-arm have no effect.

## Timing
- Datapath is combinational, 0-cycle latency:
  - m_axis_tvalid = CAPTURE & s_axis_tvalid
  - s_axis_tready = CAPTURE ? m_axis_tready : 1
- Outside CAPTURE every input beat is accepted and dropped.
- State register updates on the clock edge after the qualifying condition:
  - The trig edge cycle itself is still ARMED, so its beat is dropped.
  - The first forwarded beat is the one accepted in the first CAPTURE cycle.
- trig_d is always registered. An edge occurring in IDLE or CAPTURE is ignored and not queued.
- arm and a trig edge in the same IDLE cycle: the state goes to ARMED and the trig edge is discarded.
- abort in the same cycle as the burst-ending tlast: the burst ends, the next state is IDLE, and done pulses.
- cfg_len_m1=0: every beat carries tlast.
- Asynchronous reset: all state cleared; IDLE; counters, stop_pending and trig_d at 0.
- Output values in reset: m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1, done=0, sts_state=0, sts_pkt_cnt=0.
- Reset asserted mid-packet drops the partial packet immediately. The downstream block must tolerate the missing tlast.

## Test plan
- Basic burst: len_m1=3, npkt=2, rearm=0, continuous valid, tready=1, arm then trig. Required: 8 beats forwarded with tlast on beats 4 and 8; done pulses with the 8th beat; state returns to IDLE; sts_pkt_cnt=2.
- Backpressure: same config with m_axis_tready toggling 1/0. Required: data order, tlast positions and s_axis_tready mirroring m_axis_tready are unchanged; no beat is lost or duplicated.
- Discard and edge: stream a counting pattern and trig at value 10, with 3 cycles in ARMED before. Required: the first forwarded tdata is 11, and all beats before it are accepted with m_axis_tvalid=0.
- Abort mid-packet: len_m1=7, npkt=0, abort asserted at beat 3 of packet 2. Required: packet 2 completes to 8 beats with tlast; done pulses; state goes to IDLE; sts_pkt_cnt=2.
- Re-arm: rearm=1, npkt=1, len_m1=1, three trig edges. Required: three 2-beat packets and three done pulses. A trig edge during CAPTURE produces no extra packet.
- Async reset mid-packet at beat 2: all outputs take their reset values immediately; a subsequent arm+trig produces a full-length first packet.

Source files
------------

// File: rtl/axis_trig_packetizer_if.sv
// AXI4-Stream handshake bundle for the trigger packetizer.
// Master drives valid/data/last; the slave side carries no tlast.
interface axis_trig_packetizer_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_trig_packetizer.sv
// Trigger-armed AXI4-Stream packetizer: forwards whole packets of a runtime length,
// a runtime number of packets per trigger, and discards input while not capturing.
//
// state      | meaning
// ST_IDLE    | waiting for arm; input accepted and dropped
// ST_ARMED   | config latched; waiting for trig rising edge (or abort)
// ST_CAPTURE | forwarding beats, inserting tlast every len_m1+1 beats
module axis_trig_packetizer #(
  parameter int TDATA_WIDTH = 8,
  parameter int LEN_WIDTH   = 20,
  parameter int NPKT_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [LEN_WIDTH-1:0]  cfg_len_m1,
  input  logic [NPKT_WIDTH-1:0] cfg_npkt,
  input  logic                  cfg_rearm,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  abort,
  axis_trig_packetizer_if.slave  s_axis,
  axis_trig_packetizer_if.master m_axis,
  output logic [1:0]            sts_state,
  output logic [NPKT_WIDTH-1:0] sts_pkt_cnt,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [NPKT_WIDTH-1:0] pkt_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [NPKT_WIDTH-1:0] npkt_q;
  logic                  rearm_q;
  logic                  stop_q;
  logic                  trig_q;

  logic                   capture;
  logic                   beat_acc;
  logic                   last_beat;
  logic                   trig_edge;
  logic                   burst_end;
  logic [NPKT_WIDTH-1:0]  pkt_inc;
  logic [TDATA_WIDTH-1:0] data_w;

  assign capture   = (state_q == ST_CAPTURE);
  assign last_beat = capture && (beat_q == len_q);
  assign trig_edge = trig && !trig_q;
  assign pkt_inc   = pkt_q + 1'b1;

  // Outside CAPTURE the stream is always accepted so upstream never stalls.
  assign s_axis.tready = capture ? m_axis.tready : 1'b1;
  assign beat_acc      = capture && s_axis.tvalid && m_axis.tready;

  assign data_w        = s_axis.tdata;
  assign m_axis.tdata  = data_w;
  assign m_axis.tvalid = capture && s_axis.tvalid;
  assign m_axis.tlast  = last_beat;

  // Burst only ends on a packet boundary, so an abort never truncates a packet.
  assign burst_end = beat_acc && last_beat &&
                     (((npkt_q != '0) && (pkt_inc == npkt_q)) || stop_q);

  assign done        = burst_end;
  assign sts_state   = state_q;
  assign sts_pkt_cnt = pkt_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      pkt_q   <= '0;
      len_q   <= '0;
      npkt_q  <= '0;
      rearm_q <= 1'b0;
      stop_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      trig_q <= trig;
      case (state_q)
        ST_IDLE: begin
          if (arm && !abort) begin
            state_q <= ST_ARMED;
            len_q   <= cfg_len_m1;
            npkt_q  <= cfg_npkt;
            rearm_q <= cfg_rearm;
            beat_q  <= '0;
            pkt_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (trig_edge) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (beat_acc) begin
            if (last_beat) begin
              beat_q <= '0;
              pkt_q  <= pkt_inc;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
          if (burst_end) begin
            stop_q <= 1'b0;
            if (rearm_q && !stop_q && !abort) begin
              state_q <= ST_ARMED;
              len_q   <= cfg_len_m1;
              npkt_q  <= cfg_npkt;
              rearm_q <= cfg_rearm;
              beat_q  <= '0;
              pkt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (abort) begin
            stop_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_trig_packetizer.sv
// Bench for axis_trig_packetizer: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the packetizer rules.
module tb_axis_trig_packetizer;
  localparam int DW = 8;
  localparam int LW = 20;
  localparam int NW = 8;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic [LW-1:0] cfg_len_m1 = '0;
  logic [NW-1:0] cfg_npkt = '0;
  logic          cfg_rearm = 1'b0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    sts_state;
  logic [NW-1:0] sts_pkt_cnt;
  logic          done;

  axis_trig_packetizer_if #(.TDATA_WIDTH(DW)) s_if ();
  axis_trig_packetizer_if #(.TDATA_WIDTH(DW)) m_if ();

  always #5 aclk = ~aclk;

  axis_trig_packetizer #(.TDATA_WIDTH(DW), .LEN_WIDTH(LW), .NPKT_WIDTH(NW)) dut (
    .aclk        (aclk),
    .resetn      (resetn),
    .cfg_len_m1  (cfg_len_m1),
    .cfg_npkt    (cfg_npkt),
    .cfg_rearm   (cfg_rearm),
    .arm         (arm),
    .trig        (trig),
    .abort       (abort),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .sts_state   (sts_state),
    .sts_pkt_cnt (sts_pkt_cnt),
    .done        (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 forwarding.
  int  md, mb, mp, mlen, mnpkt;
  bit  mrearm, mstop, mtrig;
  int  obs_data[$];
  bit  obs_last[$];
  int  done_cnt = 0;
  bit  beat_taken;

  task automatic model_reset();
    md = 0; mb = 0; mp = 0; mlen = 0; mnpkt = 0;
    mrearm = 0; mstop = 0; mtrig = 0;
  endtask

  task automatic eval_cycle();
    bit cap, e_rdy, e_last, acc, fwd, b_end, trg_edge, reload;
    cap    = (md == 2);
    e_rdy  = cap ? m_if.tready : 1'b1;
    e_last = cap && (mb == mlen);
    acc    = s_if.tvalid && e_rdy;
    fwd    = cap && acc;
    b_end  = fwd && e_last && (((mnpkt != 0) && (((mp + 1) % 256) == mnpkt)) || mstop);
    check_val("s_tready", s_if.tready, e_rdy);
    check_val("m_tvalid", m_if.tvalid, cap && s_if.tvalid);
    check_val("m_tlast", m_if.tlast, e_last);
    if (cap && s_if.tvalid) check_val("m_tdata", m_if.tdata, s_if.tdata);
    check_val("done", done, b_end);
    check_val("sts_state", sts_state, md);
    check_val("sts_pkt_cnt", sts_pkt_cnt, mp);
    if (m_if.tvalid && m_if.tready) begin
      obs_data.push_back(int'(m_if.tdata));
      obs_last.push_back(m_if.tlast);
    end
    if (done) done_cnt++;
    beat_taken = acc;
    if (!resetn) begin
      model_reset();
    end else begin
      trg_edge = trig && !mtrig;
      reload   = 0;
      if (md == 0) begin
        if (arm && !abort) begin md = 1; reload = 1; end
      end else if (md == 1) begin
        if (abort) md = 0;
        else if (trg_edge) md = 2;
      end else begin
        if (fwd) begin
          if (e_last) begin mb = 0; mp = (mp + 1) % 256; end
          else mb++;
        end
        if (b_end) begin
          md     = (mrearm && !mstop && !abort) ? 1 : 0;
          reload = (md == 1);
          mstop  = 0;
        end else if (abort) begin
          mstop = 1;
        end
      end
      if (reload) begin
        mlen = int'(cfg_len_m1); mnpkt = int'(cfg_npkt); mrearm = cfg_rearm;
        mb = 0; mp = 0;
      end
      mtrig = trig;
    end
  endtask

  // Counting source: data advances only when the beat was taken.
  task automatic step();
    @(negedge aclk);
    eval_cycle();
    @(posedge aclk);
    #1;
    if (beat_taken) s_if.tdata = s_if.tdata + 1'b1;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    done_cnt = 0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (toggle) m_if.tready = (i % 2 == 0);
      step();
    end
    m_if.tready = 1'b1;
    check_val("done_seen", done_cnt - d0, 1);
  endtask

  task automatic arm_and_trig(output logic [DW-1:0] trig_data);
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; trig_data = s_if.tdata; step(); trig = 1'b0;
  endtask

  task automatic check_packet_run(input string tag, input int nbeats, input int plen,
                                  input logic [DW-1:0] first);
    check_val({tag, "_count"}, obs_data.size(), nbeats);
    for (int i = 0; i < obs_data.size(); i++) begin
      check_val({tag, "_data"}, obs_data[i], 32'(8'(first + i)));
      check_val({tag, "_last"}, obs_last[i], ((i % plen) == plen - 1));
    end
  endtask

  logic [DW-1:0] tdat;

  initial begin
    s_if.tvalid = 1'b1;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    model_reset();
    #1;
    check_val("rst_tvalid", m_if.tvalid, 0);
    check_val("rst_tready", s_if.tready, 1);
    check_val("rst_state", sts_state, 0);
    repeat (3) step();
    resetn = 1'b1;

    // Basic burst: 2 packets of 4.
    clear_obs();
    cfg_len_m1 = 3; cfg_npkt = 2; cfg_rearm = 0;
    arm_and_trig(tdat);
    run_until_done(40, 1'b0);
    check_packet_run("basic", 8, 4, tdat + 1'b1);
    check_val("basic_state", sts_state, 0);
    check_val("basic_pkts", sts_pkt_cnt, 2);

    // Backpressure: same config, downstream ready toggling.
    clear_obs();
    arm_and_trig(tdat);
    run_until_done(60, 1'b1);
    check_packet_run("bp", 8, 4, tdat + 1'b1);
    check_val("bp_pkts", sts_pkt_cnt, 2);

    // Discard and edge: trigger lands on tdata 10 after 3 armed cycles.
    clear_obs();
    cfg_len_m1 = 3; cfg_npkt = 1;
    s_if.tdata = 8'd6;
    arm = 1'b1; step(); arm = 1'b0;
    repeat (3) step();
    check_val("disc_pre_fwd", obs_data.size(), 0);
    trig = 1'b1; step(); trig = 1'b0;
    run_until_done(20, 1'b0);
    check_val("disc_first", obs_data[0], 11);
    check_packet_run("disc", 4, 4, 8'd11);

    // Abort at beat 3 of packet 2 in unlimited mode.
    clear_obs();
    cfg_len_m1 = 7; cfg_npkt = 0; cfg_rearm = 0;
    arm_and_trig(tdat);
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      abort = (obs_data.size() == 10);
      step();
    end
    abort = 1'b0;
    check_val("abort_done", done_cnt, 1);
    check_packet_run("abort", 16, 8, tdat + 1'b1);
    check_val("abort_state", sts_state, 0);
    check_val("abort_pkts", sts_pkt_cnt, 2);

    // Re-arm: three single-packet bursts, one stray edge mid-capture.
    clear_obs();
    cfg_len_m1 = 1; cfg_npkt = 1; cfg_rearm = 1;
    arm = 1'b1; step(); arm = 1'b0;
    tdat = s_if.tdata;
    for (int k = 0; k < 3; k++) begin
      trig = 1'b1; step();
      trig = 1'b0; step();
      trig = (k == 0); step();
      trig = 1'b0; step();
      step();
    end
    check_val("rearm_done", done_cnt, 3);
    check_val("rearm_count", obs_data.size(), 6);
    for (int i = 0; i < obs_last.size(); i++) check_val("rearm_last", obs_last[i], i % 2);
    check_val("rearm_state", sts_state, 1);
    abort = 1'b1; step(); abort = 1'b0;
    check_val("rearm_abort_state", sts_state, 0);

    // Asynchronous reset after 2 beats of a 6-beat packet.
    clear_obs();
    cfg_len_m1 = 5; cfg_npkt = 1; cfg_rearm = 0;
    arm_and_trig(tdat);
    for (int i = 0; i < 10 && obs_data.size() < 2; i++) step();
    check_val("ar_pre_beats", obs_data.size(), 2);
    #2 resetn = 1'b0;
    #1;
    check_val("ar_tvalid", m_if.tvalid, 0);
    check_val("ar_tlast", m_if.tlast, 0);
    check_val("ar_tready", s_if.tready, 1);
    check_val("ar_done", done, 0);
    check_val("ar_state", sts_state, 0);
    check_val("ar_pkts", sts_pkt_cnt, 0);
    model_reset();
    step(); step();
    resetn = 1'b1;
    clear_obs();
    arm_and_trig(tdat);
    run_until_done(30, 1'b0);
    check_packet_run("ar_after", 6, 6, tdat + 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      s_if.tvalid = ($urandom_range(0, 3) != 0);
      m_if.tready = ($urandom_range(0, 3) != 0);
      s_if.tdata  = DW'($urandom);
      arm         = ($urandom_range(0, 7) == 0);
      trig        = ($urandom_range(0, 5) == 0);
      abort       = ($urandom_range(0, 60) == 0);
      cfg_len_m1  = LW'($urandom_range(0, 4));
      cfg_npkt    = NW'($urandom_range(0, 3));
      cfg_rearm   = $urandom_range(0, 1) == 1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
